// File: rtl/axi_fifo_3.sv
// axi_fifo_3: AXI-stream FIFO, block RAM plus two-stage output pipeline, registered count/flags.
// Define AXI_FIFO_TLAST_EN to carry tlast alongside tdata.
module axi_fifo_3 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ALMOST_FULL_THRESH = 16,
  parameter int ALMOST_EMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
`ifdef AXI_FIFO_TLAST_EN
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tlast,
`endif
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH+1:0] data_cnt,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef AXI_FIFO_TLAST_EN
  localparam int W = DATA_WIDTH + 1;
`else
  localparam int W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH+1:0] AF = ALMOST_FULL_THRESH[ADDR_WIDTH+1:0];
  localparam logic [ADDR_WIDTH+1:0] AE = ALMOST_EMPTY_THRESH[ADDR_WIDTH+1:0];
  logic [W-1:0] ram [DEPTH];
  logic [W-1:0] d0, d1, wr_word;
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_ptr_q;
  logic d0_v, d1_v, ram_full, ram_empty, wr_en, rd_en, d1_ld;
`ifdef AXI_FIFO_TLAST_EN
  assign wr_word = {s_axis_tlast, s_axis_tdata};
  assign m_axis_tlast = d1[DATA_WIDTH];
`else
  assign wr_word = s_axis_tdata;
`endif
  assign ram_full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  // The read side compares against the write pointer one cycle late, so a
  // freshly written word is never read from the RAM in the very next cycle.
  assign ram_empty = wr_ptr_q == rd_ptr;
  assign s_axis_tready = !ram_full;
  assign wr_en = s_axis_tvalid && s_axis_tready;
  assign d1_ld = m_axis_tready || !d1_v;
  assign rd_en = !ram_empty && (!(d0_v && d1_v) || m_axis_tready);
  assign m_axis_tvalid = d1_v;
  assign m_axis_tdata = d1[DATA_WIDTH-1:0];
  always_ff @(posedge clk)
    if (wr_en) ram[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_ptr_q <= '0;
      d0 <= '0;
      d1 <= '0;
      d0_v <= 1'b0;
      d1_v <= 1'b0;
      data_cnt <= '0;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_en};
      rd_ptr <= rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_en};
      wr_ptr_q <= wr_ptr;
      if (d1_ld) begin
        d1 <= d0;
        d1_v <= d0_v;
      end
      if (rd_en) begin
        d0 <= ram[rd_ptr[ADDR_WIDTH-1:0]];
        d0_v <= 1'b1;
      end else if (d1_ld) d0_v <= 1'b0;
      data_cnt <= {1'b0, wr_ptr - rd_ptr} + {{(ADDR_WIDTH+1){1'b0}}, d0_v} +
                  {{(ADDR_WIDTH+1){1'b0}}, d1_v};
      almost_full <= data_cnt >= AF;
      almost_empty <= data_cnt <= AE;
      overflow <= s_axis_tvalid && !s_axis_tready;
    end
endmodule

// File: tb/tb_axi_fifo_3.sv
// tb_axi_fifo_3: directed bench for axi_fifo_3 with DATA_WIDTH=16, ADDR_WIDTH=3, thresholds 6/1.
module tb_axi_fifo_3;
  localparam int DW = 16, AW = 3;
  logic clk = 1'b0, reset_n = 1'b1;
  logic s_axis_tvalid = 1'b0, s_axis_tready, m_axis_tvalid, m_axis_tready = 1'b0;
  logic almost_full, almost_empty, overflow;
  logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic [AW+1:0] data_cnt;
`ifdef AXI_FIFO_TLAST_EN
  logic s_axis_tlast = 1'b0, m_axis_tlast;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  axi_fifo_3 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_THRESH(6), .ALMOST_EMPTY_THRESH(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
`ifdef AXI_FIFO_TLAST_EN
    .s_axis_tlast(s_axis_tlast), .m_axis_tlast(m_axis_tlast),
`endif
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tready(m_axis_tready),
    .data_cnt(data_cnt), .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready got=%b exp=1", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 16'h0) begin failures++; $display("FAIL reset_m_tdata got=%h exp=0000", m_axis_tdata); end
    checks++; if (data_cnt !== 5'd0) begin failures++; $display("FAIL reset_data_cnt got=%0d exp=0", data_cnt); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    step();
    step();
    reset_n = 1'b1;
  endtask
  task automatic test_single();
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'h1234;
    step();
    s_axis_tvalid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL single_early_valid edge+%0d got=%b exp=0", i, m_axis_tvalid); end
    end
    step();
    checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 16'h1234) begin failures++; $display("FAIL single_tdata got=%h exp=1234", m_axis_tdata); end
    checks++; if (data_cnt !== 5'd1) begin failures++; $display("FAIL single_data_cnt got=%0d exp=1", data_cnt); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL single_almost_empty got=%b exp=1", almost_empty); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h1234) begin failures++; $display("FAIL single_hold got=%b/%h exp=1/1234", m_axis_tvalid, m_axis_tdata); end
    end
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", m_axis_tvalid); end
    repeat (3) step();
    checks++; if (data_cnt !== 5'd0) begin failures++; $display("FAIL single_cnt_empty got=%0d exp=0", data_cnt); end
  endtask
  task automatic test_fill();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 16'(i);
      checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL fill_accept beat=%0d got=%b exp=1", i, s_axis_tready); end
      step();
    end
    s_axis_tdata = 16'h000A;
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL fill_full_tready got=%b exp=0", s_axis_tready); end
    step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow1 got=%b exp=1", overflow); end
    s_axis_tdata = 16'h000B;
    step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow2 got=%b exp=1", overflow); end
    s_axis_tvalid = 1'b0;
    step();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_overflow_clear got=%b exp=0", overflow); end
    checks++; if (data_cnt !== 5'd10) begin failures++; $display("FAIL fill_data_cnt got=%0d exp=10", data_cnt); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL fill_almost_full got=%b exp=1", almost_full); end
    checks++; if (almost_empty !== 1'b0) begin failures++; $display("FAIL fill_almost_empty got=%b exp=0", almost_empty); end
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0000) begin failures++; $display("FAIL fill_head got=%b/%h exp=1/0000", m_axis_tvalid, m_axis_tdata); end
  endtask
  task automatic test_drain();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(i)) begin failures++; $display("FAIL drain_word %0d got=%b/%h exp=1/%h", i, m_axis_tvalid, m_axis_tdata, 16'(i)); end
      checks++; if (data_cnt !== 5'((i == 0) ? 10 : 11 - i)) begin failures++; $display("FAIL drain_cnt %0d got=%0d exp=%0d", i, data_cnt, (i == 0) ? 10 : 11 - i); end
      checks++; if (almost_full !== (i <= 6)) begin failures++; $display("FAIL drain_almost_full %0d got=%b exp=%b", i, almost_full, i <= 6); end
      step();
    end
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL drain_done got=%b exp=0", m_axis_tvalid); end
    checks++; if (data_cnt !== 5'd1 || almost_empty !== 1'b0) begin failures++; $display("FAIL drain_pre_ae got=%0d/%b exp=1/0", data_cnt, almost_empty); end
    step();
    checks++; if (data_cnt !== 5'd0 || almost_empty !== 1'b1) begin failures++; $display("FAIL drain_ae got=%0d/%b exp=0/1", data_cnt, almost_empty); end
  endtask
  task automatic test_back_to_back();
    int got = 0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 103; c++) begin
      s_axis_tvalid = c < 100;
      s_axis_tdata = 16'(16'h0100 + c);
      if (c < 100) begin
        checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL stream_tready c=%0d got=%b exp=1", c, s_axis_tready); end
      end
      step();
      if (c < 3) begin
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL stream_early c=%0d got=%b exp=0", c, m_axis_tvalid); end
      end else begin
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(16'h0100 + c - 3)) begin failures++; $display("FAIL stream_word c=%0d got=%b/%h exp=1/%h", c, m_axis_tvalid, m_axis_tdata, 16'(16'h0100 + c - 3)); end
        else got++;
      end
    end
    s_axis_tvalid = 1'b0;
    step();
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL stream_end got=%b exp=0", m_axis_tvalid); end
    checks++; if (got != 100) begin failures++; $display("FAIL stream_count got=%0d exp=100", got); end
  endtask
  task automatic test_reset_mid();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 16'(16'h0050 + i);
      step();
    end
    s_axis_tvalid = 1'b0;
    repeat (3) step();
    checks++; if (m_axis_tvalid !== 1'b1 || data_cnt !== 5'd5) begin failures++; $display("FAIL mid_before got=%b/%0d exp=1/5", m_axis_tvalid, data_cnt); end
    reset_n = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (data_cnt !== 5'd0) begin failures++; $display("FAIL mid_data_cnt got=%0d exp=0", data_cnt); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL mid_almost_empty got=%b exp=1", almost_empty); end
    checks++; if (s_axis_tready !== 1'b1 || m_axis_tdata !== 16'h0) begin failures++; $display("FAIL mid_outs got=%b/%h exp=1/0000", s_axis_tready, m_axis_tdata); end
    step();
    reset_n = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'hBEEF;
    step();
    s_axis_tvalid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL mid_beef_early edge+%0d got=%b exp=0", i, m_axis_tvalid); end
    end
    step();
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'hBEEF) begin failures++; $display("FAIL mid_beef got=%b/%h exp=1/beef", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    repeat (3) step();
  endtask
`ifdef AXI_FIFO_TLAST_EN
  task automatic test_tlast();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 16'(16'h0060 + i);
      s_axis_tlast = i == 3;
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (3) step();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(16'h0060 + i) || m_axis_tlast !== (i == 3)) begin failures++; $display("FAIL tlast_beat %0d got=%b/%h/%b exp=1/%h/%b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 16'(16'h0060 + i), i == 3); end
      step();
    end
    m_axis_tready = 1'b0;
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_reset_mid();
`ifdef AXI_FIFO_TLAST_EN
    test_tlast();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
